// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of the five-stage MIPS pipeline. It owns the program
// counter and issues one word fetch per cycle to instruction memory over a
// ready-gated request interface. It also presents one instruction per cycle to
// the F/D pipeline register through a single-entry output buffer.
//
// Branch/jump redirects use single-delay-slot semantics. The instruction after
// a branch always executes. If that delay slot has not been fetched yet when
// the redirect arrives, the target is parked in a pending register. The target
// is then applied once the delay slot has been accepted from memory.
//
// Ports
//   clk            in   clock, rising-edge
//   reset          in   synchronous, active-high
//   stall          in   F/D register not writing this cycle
//   redirect_valid in   taken branch/jump resolved in D this cycle
//   redirect_pc    in   redirect target (bits [1:0] ignored)
//   imem_req       out  fetch request this cycle
//   imem_addr      out  word address of the request (current fetch PC)
//   imem_ready     in   memory completes the request this cycle
//   imem_rdata     in   instruction word, valid with imem_req && imem_ready
//   F_PC           out  PC of the presented instruction
//   F_Instr        out  presented instruction, 0 (nop) when F_valid is low
//   F_valid        out  a real instruction is presented
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_Instr,
  output logic        F_valid
);

  // Redirect targets are word addresses; the byte offset is discarded.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  logic [31:0] fetch_pc;
  logic        buf_valid;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;
  logic        pending_valid;
  logic [31:0] pending_pc;

  logic        consume;
  logic        accept;
  logic [31:0] redirect_target;

  // Request control: a request is issued only when the output buffer will be
  // free at the next edge. No request is issued in a redirect cycle, because
  // fetch_pc is about to change or is waiting on the delay slot.
  always_comb begin
    consume         = buf_valid && !stall;
    imem_req        = !redirect_valid && (!buf_valid || consume);
    accept          = imem_req && imem_ready;
    redirect_target = word_align(redirect_pc);
  end

  assign imem_addr = fetch_pc;
  assign F_valid   = buf_valid;
  assign F_PC      = buf_pc;
  assign F_Instr   = buf_valid ? buf_instr : 32'h0;

  // ---- fetch -> F/D boundary: PC, output buffer and deferred redirect ----
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc      <= RESET_PC;
      buf_valid     <= 1'b0;
      buf_pc        <= 32'h0;
      buf_instr     <= 32'h0;
      pending_valid <= 1'b0;
      pending_pc    <= 32'h0;
    end else if (redirect_valid) begin
      if (buf_valid) begin
        // The buffer holds the delay slot, so the target can be fetched next.
        fetch_pc <= redirect_target;
        if (consume) begin
          buf_valid <= 1'b0;
        end
      end else begin
        // The delay slot is still to come from fetch_pc; park the target.
        pending_valid <= 1'b1;
        pending_pc    <= redirect_target;
      end
    end else if (accept) begin
      buf_valid <= 1'b1;
      buf_pc    <= fetch_pc;
      buf_instr <= imem_rdata;
      if (pending_valid) begin
        fetch_pc      <= pending_pc;
        pending_valid <= 1'b0;
      end else begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end else if (consume) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic        F_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected presentation for one cycle.
  typedef struct {
    bit          v;
    bit          pc_chk;
    logic [31:0] pc;
  } exp_t;

  // One cycle of stimulus.
  // push/pv/ppc: the presentation expected in the following cycle.
  // ca/addr and cr/req: optional imem_addr and imem_req checks for this cycle.
  typedef struct {
    bit          rst;
    bit          stl;
    bit          rdy;
    bit          rv;
    logic [31:0] rp;
    bit          push;
    bit          pv;
    logic [31:0] ppc;
    bit          ca;
    logic [31:0] addr;
    bit          cr;
    bit          req;
  } cyc_t;

  exp_t exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .F_PC           (F_PC),
    .F_Instr        (F_Instr),
    .F_valid        (F_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory model: the content is a scrambled function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  function automatic cyc_t cy(input bit rst, input bit stl, input bit rdy, input bit rv,
                              input logic [31:0] rp, input bit push, input bit pv,
                              input logic [31:0] ppc, input bit ca, input logic [31:0] addr,
                              input bit cr, input bit req);
    cyc_t c;
    c.rst = rst; c.stl = stl; c.rdy = rdy; c.rv = rv; c.rp = rp;
    c.push = push; c.pv = pv; c.ppc = ppc;
    c.ca = ca; c.addr = addr; c.cr = cr; c.req = req;
    return c;
  endfunction

  // Drives one cycle of inputs and queues the presentation expected in the next cycle.
  task automatic apply_cycle(input cyc_t c);
    reset          = c.rst;
    stall          = c.stl;
    imem_ready     = c.rdy;
    redirect_valid = c.rv;
    redirect_pc    = c.rp;
    if (c.push) exp_q.push_back('{c.pv, c.rst, c.ppc});
  endtask

  // Leaves the bench in the first cycle after reset, with the reset state queued.
  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back('{1'b0, 1'b1, 32'h0});
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++; if (F_valid !== 1'b0) $display("FAIL reset F_valid: got %0b required 0", F_valid); else n_pass++;
    n_checks++; if (F_PC !== 32'h0) $display("FAIL reset F_PC: got %h required 00000000", F_PC); else n_pass++;
    n_checks++; if (F_Instr !== 32'h0) $display("FAIL reset F_Instr: got %h required 00000000", F_Instr); else n_pass++;
    n_checks++; if (imem_req !== 1'b1) $display("FAIL reset imem_req: got %0b required 1", imem_req); else n_pass++;
    n_checks++; if (imem_addr !== 32'h3000) $display("FAIL reset imem_addr: got %h required 00003000", imem_addr); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_sequential();
    string nm = "seq";
    cyc_t t[4];
    do_reset();
    t[0] = cy(0,0,1,0,0, 1,1,32'h3000, 1,32'h3000, 1,1);
    t[1] = cy(0,0,1,0,0, 1,1,32'h3004, 1,32'h3004, 1,1);
    t[2] = cy(0,0,1,0,0, 1,1,32'h3008, 1,32'h3008, 1,1);
    t[3] = cy(0,0,1,0,0, 0,0,32'h0,    1,32'h300C, 1,1);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      logic [31:0] ei;
      apply_cycle(t[i]);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL %s c%0d scoreboard: queue empty, required an entry", nm, i);
      else begin
        n_pass++;
        e = exp_q.pop_front();
        ei = e.v ? mem_word(e.pc) : 32'h0;
        n_checks++; if (F_valid !== e.v) $display("FAIL %s c%0d F_valid: got %0b required %0b", nm, i, F_valid, e.v); else n_pass++;
        if (e.v || e.pc_chk) begin
          n_checks++; if (F_PC !== e.pc) $display("FAIL %s c%0d F_PC: got %h required %h", nm, i, F_PC, e.pc); else n_pass++;
        end
        n_checks++; if (F_Instr !== ei) $display("FAIL %s c%0d F_Instr: got %h required %h", nm, i, F_Instr, ei); else n_pass++;
      end
      if (t[i].ca) begin
        n_checks++; if (imem_addr !== t[i].addr) $display("FAIL %s c%0d imem_addr: got %h required %h", nm, i, imem_addr, t[i].addr); else n_pass++;
      end
      if (t[i].cr) begin
        n_checks++; if (imem_req !== t[i].req) $display("FAIL %s c%0d imem_req: got %0b required %0b", nm, i, imem_req, t[i].req); else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    string nm = "stall";
    cyc_t t[7];
    do_reset();
    t[0] = cy(0,0,1,0,0, 1,1,32'h3000, 0,32'h0,    0,0);
    t[1] = cy(0,0,1,0,0, 1,1,32'h3004, 1,32'h3004, 1,1);
    t[2] = cy(0,1,1,0,0, 1,1,32'h3004, 0,32'h0,    1,0);
    t[3] = cy(0,1,1,0,0, 1,1,32'h3004, 0,32'h0,    1,0);
    t[4] = cy(0,1,1,0,0, 1,1,32'h3004, 0,32'h0,    1,0);
    t[5] = cy(0,0,1,0,0, 1,1,32'h3008, 1,32'h3008, 1,1);
    t[6] = cy(0,0,1,0,0, 0,0,32'h0,    1,32'h300C, 1,1);
    for (int i = 0; i < 7; i++) begin
      exp_t e;
      logic [31:0] ei;
      apply_cycle(t[i]);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL %s c%0d scoreboard: queue empty, required an entry", nm, i);
      else begin
        n_pass++;
        e = exp_q.pop_front();
        ei = e.v ? mem_word(e.pc) : 32'h0;
        n_checks++; if (F_valid !== e.v) $display("FAIL %s c%0d F_valid: got %0b required %0b", nm, i, F_valid, e.v); else n_pass++;
        if (e.v || e.pc_chk) begin
          n_checks++; if (F_PC !== e.pc) $display("FAIL %s c%0d F_PC: got %h required %h", nm, i, F_PC, e.pc); else n_pass++;
        end
        n_checks++; if (F_Instr !== ei) $display("FAIL %s c%0d F_Instr: got %h required %h", nm, i, F_Instr, ei); else n_pass++;
      end
      if (t[i].ca) begin
        n_checks++; if (imem_addr !== t[i].addr) $display("FAIL %s c%0d imem_addr: got %h required %h", nm, i, imem_addr, t[i].addr); else n_pass++;
      end
      if (t[i].cr) begin
        n_checks++; if (imem_req !== t[i].req) $display("FAIL %s c%0d imem_req: got %0b required %0b", nm, i, imem_req, t[i].req); else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wait_states();
    string nm = "wait";
    cyc_t t[6];
    do_reset();
    t[0] = cy(0,0,1,0,0, 1,1,32'h3000, 1,32'h3000, 1,1);
    t[1] = cy(0,0,1,0,0, 1,1,32'h3004, 1,32'h3004, 1,1);
    t[2] = cy(0,0,0,0,0, 1,0,32'h0,    1,32'h3008, 1,1);
    t[3] = cy(0,0,0,0,0, 1,0,32'h0,    1,32'h3008, 1,1);
    t[4] = cy(0,0,1,0,0, 1,1,32'h3008, 1,32'h3008, 1,1);
    t[5] = cy(0,0,1,0,0, 0,0,32'h0,    1,32'h300C, 1,1);
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      logic [31:0] ei;
      apply_cycle(t[i]);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL %s c%0d scoreboard: queue empty, required an entry", nm, i);
      else begin
        n_pass++;
        e = exp_q.pop_front();
        ei = e.v ? mem_word(e.pc) : 32'h0;
        n_checks++; if (F_valid !== e.v) $display("FAIL %s c%0d F_valid: got %0b required %0b", nm, i, F_valid, e.v); else n_pass++;
        if (e.v || e.pc_chk) begin
          n_checks++; if (F_PC !== e.pc) $display("FAIL %s c%0d F_PC: got %h required %h", nm, i, F_PC, e.pc); else n_pass++;
        end
        n_checks++; if (F_Instr !== ei) $display("FAIL %s c%0d F_Instr: got %h required %h", nm, i, F_Instr, ei); else n_pass++;
      end
      if (t[i].ca) begin
        n_checks++; if (imem_addr !== t[i].addr) $display("FAIL %s c%0d imem_addr: got %h required %h", nm, i, imem_addr, t[i].addr); else n_pass++;
      end
      if (t[i].cr) begin
        n_checks++; if (imem_req !== t[i].req) $display("FAIL %s c%0d imem_req: got %0b required %0b", nm, i, imem_req, t[i].req); else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect_full();
    string nm = "redir_full";
    cyc_t t[6];
    do_reset();
    t[0] = cy(0,0,1,0,0,            1,1,32'h3000, 1,32'h3000, 1,1);
    t[1] = cy(0,0,1,0,0,            1,1,32'h3004, 1,32'h3004, 1,1);
    t[2] = cy(0,0,1,0,0,            1,1,32'h3008, 1,32'h3008, 1,1);
    t[3] = cy(0,0,1,1,32'h0000_3101, 1,0,32'h0,    0,32'h0,    1,0);
    t[4] = cy(0,0,1,0,0,            1,1,32'h3100, 1,32'h3100, 1,1);
    t[5] = cy(0,0,1,0,0,            0,0,32'h0,    1,32'h3104, 1,1);
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      logic [31:0] ei;
      apply_cycle(t[i]);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL %s c%0d scoreboard: queue empty, required an entry", nm, i);
      else begin
        n_pass++;
        e = exp_q.pop_front();
        ei = e.v ? mem_word(e.pc) : 32'h0;
        n_checks++; if (F_valid !== e.v) $display("FAIL %s c%0d F_valid: got %0b required %0b", nm, i, F_valid, e.v); else n_pass++;
        if (e.v || e.pc_chk) begin
          n_checks++; if (F_PC !== e.pc) $display("FAIL %s c%0d F_PC: got %h required %h", nm, i, F_PC, e.pc); else n_pass++;
        end
        n_checks++; if (F_Instr !== ei) $display("FAIL %s c%0d F_Instr: got %h required %h", nm, i, F_Instr, ei); else n_pass++;
      end
      if (t[i].ca) begin
        n_checks++; if (imem_addr !== t[i].addr) $display("FAIL %s c%0d imem_addr: got %h required %h", nm, i, imem_addr, t[i].addr); else n_pass++;
      end
      if (t[i].cr) begin
        n_checks++; if (imem_req !== t[i].req) $display("FAIL %s c%0d imem_req: got %0b required %0b", nm, i, imem_req, t[i].req); else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect_empty();
    string nm = "redir_empty";
    cyc_t t[8];
    do_reset();
    t[0] = cy(0,0,1,0,0,            1,1,32'h3000, 1,32'h3000, 1,1);
    t[1] = cy(0,0,1,0,0,            1,1,32'h3004, 1,32'h3004, 1,1);
    t[2] = cy(0,0,0,0,0,            1,0,32'h0,    1,32'h3008, 1,1);
    t[3] = cy(0,0,0,1,32'h0000_3200, 1,0,32'h0,    1,32'h3008, 1,0);
    t[4] = cy(0,0,1,0,0,            1,1,32'h3008, 1,32'h3008, 1,1);
    t[5] = cy(0,0,1,0,0,            1,1,32'h3200, 1,32'h3200, 1,1);
    t[6] = cy(0,0,1,0,0,            1,1,32'h3204, 1,32'h3204, 1,1);
    t[7] = cy(0,0,1,0,0,            0,0,32'h0,    1,32'h3208, 1,1);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      logic [31:0] ei;
      apply_cycle(t[i]);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL %s c%0d scoreboard: queue empty, required an entry", nm, i);
      else begin
        n_pass++;
        e = exp_q.pop_front();
        ei = e.v ? mem_word(e.pc) : 32'h0;
        n_checks++; if (F_valid !== e.v) $display("FAIL %s c%0d F_valid: got %0b required %0b", nm, i, F_valid, e.v); else n_pass++;
        if (e.v || e.pc_chk) begin
          n_checks++; if (F_PC !== e.pc) $display("FAIL %s c%0d F_PC: got %h required %h", nm, i, F_PC, e.pc); else n_pass++;
        end
        n_checks++; if (F_Instr !== ei) $display("FAIL %s c%0d F_Instr: got %h required %h", nm, i, F_Instr, ei); else n_pass++;
      end
      if (t[i].ca) begin
        n_checks++; if (imem_addr !== t[i].addr) $display("FAIL %s c%0d imem_addr: got %h required %h", nm, i, imem_addr, t[i].addr); else n_pass++;
      end
      if (t[i].cr) begin
        n_checks++; if (imem_req !== t[i].req) $display("FAIL %s c%0d imem_req: got %0b required %0b", nm, i, imem_req, t[i].req); else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    string nm = "wrap";
    cyc_t t[6];
    do_reset();
    t[0] = cy(0,0,1,0,0,            1,1,32'h3000,      1,32'h3000,      1,1);
    t[1] = cy(0,0,1,0,0,            1,1,32'h3004,      1,32'h3004,      1,1);
    t[2] = cy(0,0,1,1,32'hFFFF_FFFF, 1,0,32'h0,         0,32'h0,         1,0);
    t[3] = cy(0,0,1,0,0,            1,1,32'hFFFF_FFFC, 1,32'hFFFF_FFFC, 1,1);
    t[4] = cy(0,0,1,0,0,            1,1,32'h0,         1,32'h0,         1,1);
    t[5] = cy(0,0,1,0,0,            0,0,32'h0,         1,32'h4,         1,1);
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      logic [31:0] ei;
      apply_cycle(t[i]);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL %s c%0d scoreboard: queue empty, required an entry", nm, i);
      else begin
        n_pass++;
        e = exp_q.pop_front();
        ei = e.v ? mem_word(e.pc) : 32'h0;
        n_checks++; if (F_valid !== e.v) $display("FAIL %s c%0d F_valid: got %0b required %0b", nm, i, F_valid, e.v); else n_pass++;
        if (e.v || e.pc_chk) begin
          n_checks++; if (F_PC !== e.pc) $display("FAIL %s c%0d F_PC: got %h required %h", nm, i, F_PC, e.pc); else n_pass++;
        end
        n_checks++; if (F_Instr !== ei) $display("FAIL %s c%0d F_Instr: got %h required %h", nm, i, F_Instr, ei); else n_pass++;
      end
      if (t[i].ca) begin
        n_checks++; if (imem_addr !== t[i].addr) $display("FAIL %s c%0d imem_addr: got %h required %h", nm, i, imem_addr, t[i].addr); else n_pass++;
      end
      if (t[i].cr) begin
        n_checks++; if (imem_req !== t[i].req) $display("FAIL %s c%0d imem_req: got %0b required %0b", nm, i, imem_req, t[i].req); else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    string nm = "reset_mid";
    cyc_t t[8];
    do_reset();
    t[0] = cy(0,0,1,0,0,            1,1,32'h3000, 1,32'h3000, 1,1);
    t[1] = cy(0,0,1,0,0,            1,1,32'h3004, 1,32'h3004, 1,1);
    t[2] = cy(0,0,0,0,0,            1,0,32'h0,    1,32'h3008, 1,1);
    t[3] = cy(0,0,0,1,32'h0000_3200, 1,0,32'h0,    1,32'h3008, 1,0);
    t[4] = cy(1,0,0,0,0,            1,0,32'h0,    1,32'h3008, 1,1);
    t[5] = cy(0,0,1,0,0,            1,1,32'h3000, 1,32'h3000, 1,1);
    t[6] = cy(0,0,1,0,0,            1,1,32'h3004, 1,32'h3004, 1,1);
    t[7] = cy(0,0,1,0,0,            0,0,32'h0,    1,32'h3008, 1,1);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      logic [31:0] ei;
      apply_cycle(t[i]);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL %s c%0d scoreboard: queue empty, required an entry", nm, i);
      else begin
        n_pass++;
        e = exp_q.pop_front();
        ei = e.v ? mem_word(e.pc) : 32'h0;
        n_checks++; if (F_valid !== e.v) $display("FAIL %s c%0d F_valid: got %0b required %0b", nm, i, F_valid, e.v); else n_pass++;
        if (e.v || e.pc_chk) begin
          n_checks++; if (F_PC !== e.pc) $display("FAIL %s c%0d F_PC: got %h required %h", nm, i, F_PC, e.pc); else n_pass++;
        end
        n_checks++; if (F_Instr !== ei) $display("FAIL %s c%0d F_Instr: got %h required %h", nm, i, F_Instr, ei); else n_pass++;
      end
      if (t[i].ca) begin
        n_checks++; if (imem_addr !== t[i].addr) $display("FAIL %s c%0d imem_addr: got %h required %h", nm, i, imem_addr, t[i].addr); else n_pass++;
      end
      if (t[i].cr) begin
        n_checks++; if (imem_req !== t[i].req) $display("FAIL %s c%0d imem_req: got %0b required %0b", nm, i, imem_req, t[i].req); else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion before it");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_wait_states();
    test_redirect_full();
    test_redirect_empty();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the five-stage MIPS pipeline. It owns the program counter, issues word fetches to instruction memory over a ready-gated interface, and presents one instruction per cycle to the F/D pipeline register. It obeys that register's stall: while stalled, the presented instruction and PC are held. It applies branch/jump redirects with single-delay-slot semantics: the instruction after the branch always executes.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  reset, synchronous, active-high.
- stall  in  1  F/D register not writing this cycle (inverse of its write enable).
- redirect_valid  in  1  D stage resolved a taken branch/jump this cycle.
- redirect_pc  in  32  target address; bits [1:0] are ignored and treated as 00.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  32  word address of the request; equals fetch_pc.
- imem_ready  in  1  memory returns data this cycle; completes the request.
- imem_rdata  in  32  instruction word; valid when imem_req && imem_ready.
- F_PC  out  32  PC of the presented instruction.
- F_Instr  out  32  presented instruction; 32'h0 (nop) when F_valid=0.
- F_valid  out  1  a real instruction is presented.

## Operation
- State: fetch_pc (32); output buffer buf_valid/buf_pc/buf_instr; pending_valid/pending_pc (deferred redirect).
- Outputs: F_valid=buf_valid, F_PC=buf_pc, F_Instr=buf_valid?buf_instr:0.
- consume = buf_valid && !stall. FD_REG captures F_PC/F_Instr at the same edge.
- imem_req = !redirect_valid && (!buf_valid || consume). A request is issued only when the buffer will be free at the next edge.
- accept = imem_req && imem_ready. At the edge: buf <= {1, fetch_pc, imem_rdata}.
  - If pending_valid: fetch_pc <= pending_pc and pending_valid <= 0.
  - Otherwise: fetch_pc <= fetch_pc+4, with 32-bit wrap.
- No accept and consume: buf_valid <= 0. buf_pc and buf_instr retain their values.
- No accept and no consume: all state holds. imem_addr stays stable while imem_ready is low.
- Redirect cycle (redirect_valid=1): imem_req is forced 0, so no accept occurs.
  - If buf_valid=1: the buffer holds the delay slot. fetch_pc <= {redirect_pc[31:2],2'b00}. The buffer is kept, or cleared if consumed.
  - If buf_valid=0: the delay slot is not yet fetched. pending_valid <= 1 and pending_pc <= target. fetch_pc is unchanged.
  - Delay slot is never squashed. This block has no flush input.
- A second redirect while pending_valid=1 overwrites pending_pc. This is a system protocol violation and is not checked.
- Priority per edge: reset > redirect > accept > consume.

## Timing
- Reset values: fetch_pc=RESET_PC, buf_valid=0, buf_pc=0, buf_instr=0, pending_valid=0, pending_pc=0.
  - Hence F_valid=0, F_PC=0, F_Instr=0, imem_req=1, imem_addr=RESET_PC in the first cycle after reset.
- Reset mid-request discards the in-flight request and any pending redirect. The next request is at RESET_PC.
- Fetch latency: accept at the edge ending cycle N gives F_valid=1 during cycle N+1.
- Throughput: 1 instruction/cycle with imem_ready=1 and stall=0. No bubbles on the sequential path.
- Stall: F outputs are held bit-exact. imem_req=0 while the buffer is full and stalled.
- Memory wait states insert bubbles: F_valid=0, F_Instr=0.
- Redirect cost is one request-free cycle. The target instruction is presented two cycles after the redirect when ready=1.
- imem_req depends combinationally on stall and redirect_valid. There is no combinational path from imem_rdata to any output.

## Test plan
- Reset release, imem_ready=1, stall=0. Required:
  - cycle 0: imem_addr=0x3000.
  - Cycles 1,2,3: F_PC=0x3000,0x3004,0x3008 with F_valid=1.
  - imem_rdata appears on F_Instr one cycle after its request.
- Buffer holds 0x3004, stall=1 for 3 cycles. Required:
  - F_PC=0x3004 and F_Instr unchanged for all 3 cycles; imem_req=0.
  - After stall drops: 0x3008 on the following cycle.
- imem_ready=0 for 2 cycles at addr 0x3008, stall=0. Required:
  - imem_addr=0x3008 held; F_valid=0 and F_Instr=0 in the bubble cycles.
  - Then 0x3008 is presented.
- Buffer valid with 0x3008, redirect_valid=1, redirect_pc=0x3101. Required:
  - imem_req=0 in the redirect cycle.
  - Presented sequence: 0x3008, one bubble, 0x3100. Low bits are masked.
- Buffer empty (ready low), fetch_pc=0x3008, redirect to 0x3200. Required:
  - 0x3008 (delay slot) is delivered first, then 0x3200. pending_valid clears.
- Reset asserted while imem_ready=0 and pending_valid=1. Required:
  - All outputs at reset values; pending cleared.
  - Next presented PC=0x3000.
